// File: rtl/mavg_sequencer.sv
// Paces ADC samples into a 4-tap moving-average filter by replaying a 4-deep history
// as an oldest-first burst, then returns the filter result over a valid/ready handshake.
module mavg_sequencer #(
   parameter int DIV    = 2268,
   parameter int WARMUP = 4
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic              enable,
   input  logic              adc_valid,
   input  logic signed [8:0] adc_data,
   output logic              adc_ready,
   output logic signed [8:0] flt_current,
   output logic              flt_start,
   output logic              flt_reset,
   input  logic signed [8:0] flt_result,
   output logic              out_valid,
   output logic signed [8:0] out_data,
   input  logic              out_ready,
   output logic              overrun
);

   localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
   localparam logic [2:0]  WARMUP_CNT = 3'(WARMUP);

   typedef enum logic [2:0] {ACCEPT, B0, B1, B2, B3, CAP, HOLD} state_t;

   state_t            state_q, state_d;
   logic [15:0]       div_q, div_d;
   logic              tick_pend_q, tick_pend_d;
   logic              overrun_q, overrun_d;
   logic              enable_q, enable_d;
   logic [2:0]        sample_cnt_q, sample_cnt_d;
   logic signed [8:0] h0_q, h0_d, h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
   logic signed [8:0] out_data_q, out_data_d;
   logic              tick, rise, ready_int, accept;
   logic signed [8:0] beat_mux;

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      tick_pend_d  = tick_pend_q;
      overrun_d    = overrun_q;
      enable_d     = enable;
      sample_cnt_d = sample_cnt_q;
      h0_d         = h0_q;
      h1_d         = h1_q;
      h2_d         = h2_q;
      h3_d         = h3_q;
      out_data_d   = out_data_q;
      tick         = 1'b0;
      beat_mux     = '0;

      // A flush on the enable rising edge wins over a same-cycle acceptance.
      rise      = enable & ~enable_q;
      ready_int = (state_q == ACCEPT) & enable & tick_pend_q & ~rise;
      accept    = ready_int & adc_valid;

      if (!enable) begin
         div_d = '0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         tick  = 1'b1;
      end else begin
         div_d = div_q + 16'd1;
      end

      if (tick & tick_pend_q) overrun_d = 1'b1;

      if (!enable)     tick_pend_d = 1'b0;
      else if (tick)   tick_pend_d = 1'b1;
      else if (accept) tick_pend_d = 1'b0;

      if (rise) begin
         h0_d         = '0;
         h1_d         = '0;
         h2_d         = '0;
         h3_d         = '0;
         sample_cnt_d = '0;
      end else if (accept) begin
         h3_d = h2_q;
         h2_d = h1_q;
         h1_d = h0_q;
         h0_d = adc_data;
         if (sample_cnt_q != 3'd4) sample_cnt_d = sample_cnt_q + 3'd1;
      end

      case (state_q)
         ACCEPT: if (accept) state_d = B0;
         B0: begin
            beat_mux = h3_q;
            state_d  = B1;
         end
         B1: begin
            beat_mux = h2_q;
            state_d  = B2;
         end
         B2: begin
            beat_mux = h1_q;
            state_d  = B3;
         end
         B3: begin
            beat_mux = h0_q;
            state_d  = CAP;
         end
         CAP: begin
            out_data_d = flt_result;
            state_d    = (sample_cnt_q >= WARMUP_CNT) ? HOLD : ACCEPT;
         end
         HOLD: if (out_ready) state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
   end

   // Outputs are forced low while reset is asserted, except the filter reset strobe.
   always_comb begin
      adc_ready   = ready_int & ~reset;
      flt_current = reset ? 9'sd0 : beat_mux;
      flt_start   = (state_q == B3) & ~reset;
      flt_reset   = reset | rise;
      out_valid   = (state_q == HOLD) & ~reset;
      out_data    = reset ? 9'sd0 : out_data_q;
      overrun     = overrun_q & ~reset;
   end

   always_ff @(posedge CLK100MHZ) begin
      enable_q <= enable_d;
      if (reset) begin
         state_q      <= ACCEPT;
         div_q        <= '0;
         tick_pend_q  <= 1'b0;
         overrun_q    <= 1'b0;
         sample_cnt_q <= '0;
         h0_q         <= '0;
         h1_q         <= '0;
         h2_q         <= '0;
         h3_q         <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         tick_pend_q  <= tick_pend_d;
         overrun_q    <= overrun_d;
         sample_cnt_q <= sample_cnt_d;
         h0_q         <= h0_d;
         h1_q         <= h1_d;
         h2_q         <= h2_d;
         h3_q         <= h3_d;
         out_data_q   <= out_data_d;
      end
   end

endmodule
